// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus a 32-step restoring divider that stalls the pipeline.
// Produces the GPR write-back triple and the HI/LO write for the EX/MEM register.
module ex_stage #(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stallreq
);

    localparam logic [7:0] OpAnd  = 8'b0010_0100;
    localparam logic [7:0] OpOr   = 8'b0010_0101;
    localparam logic [7:0] OpXor  = 8'b0010_0110;
    localparam logic [7:0] OpNor  = 8'b0010_0111;
    localparam logic [7:0] OpSll  = 8'b0111_1100;
    localparam logic [7:0] OpSrl  = 8'b0000_0010;
    localparam logic [7:0] OpSra  = 8'b0000_0011;
    localparam logic [7:0] OpMfhi = 8'b0001_0000;
    localparam logic [7:0] OpMthi = 8'b0001_0001;
    localparam logic [7:0] OpMflo = 8'b0001_0010;
    localparam logic [7:0] OpMtlo = 8'b0001_0011;
    localparam logic [7:0] OpSlt  = 8'b0010_1010;
    localparam logic [7:0] OpSltu = 8'b0010_1011;
    localparam logic [7:0] OpAddu = 8'b0010_0001;
    localparam logic [7:0] OpSubu = 8'b0010_0011;
    localparam logic [7:0] OpDiv  = 8'b0001_1010;
    localparam logic [7:0] OpDivu = 8'b0001_1011;

    localparam logic [2:0] SelLogic = 3'b001;
    localparam logic [2:0] SelShift = 3'b010;
    localparam logic [2:0] SelMove  = 3'b011;
    localparam logic [2:0] SelArith = 3'b100;

    localparam logic [4:0] NopRegAddr = 5'd0;
    localparam logic [4:0] LastStep   = 5'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDivZero, StDone} div_state_e;

    logic        is_div;
    logic        div_signed;
    logic [31:0] dividend_abs;
    logic [31:0] divisor_abs;

    logic [31:0] logic_res;
    logic [31:0] shift_res;
    logic [31:0] arith_res;
    logic [31:0] move_res;

    div_state_e  state_q;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] divisor_q;
    logic [4:0]  cnt_q;
    logic        neg_quo_q;
    logic        neg_rem_q;
    logic [31:0] res_lo_q;
    logic [31:0] res_hi_q;

    logic [32:0] trial;
    logic [31:0] step_rem;
    logic [31:0] step_quo;

    assign is_div     = (aluop_i == OpDiv) || (aluop_i == OpDivu);
    assign div_signed = (aluop_i == OpDiv);

    assign dividend_abs = (div_signed && reg1_i[31]) ? -reg1_i : reg1_i;
    assign divisor_abs  = (div_signed && reg2_i[31]) ? -reg2_i : reg2_i;

    // Logic operations.
    always_comb begin
        logic_res = '0;
        case (aluop_i)
            OpOr:    logic_res = reg1_i | reg2_i;
            OpAnd:   logic_res = reg1_i & reg2_i;
            OpXor:   logic_res = reg1_i ^ reg2_i;
            OpNor:   logic_res = ~(reg1_i | reg2_i);
            default: logic_res = '0;
        endcase
    end

    // Shifts: reg2 is the value, reg1[4:0] the amount.
    always_comb begin
        shift_res = '0;
        case (aluop_i)
            OpSll:   shift_res = reg2_i << reg1_i[4:0];
            OpSrl:   shift_res = reg2_i >> reg1_i[4:0];
            OpSra:   shift_res = $signed(reg2_i) >>> reg1_i[4:0];
            default: shift_res = '0;
        endcase
    end

    always_comb begin
        arith_res = '0;
        case (aluop_i)
            OpAddu:  arith_res = reg1_i + reg2_i;
            OpSubu:  arith_res = reg1_i - reg2_i;
            OpSlt:   arith_res = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
            OpSltu:  arith_res = {31'd0, reg1_i < reg2_i};
            default: arith_res = '0;
        endcase
    end

    always_comb begin
        move_res = '0;
        case (aluop_i)
            OpMfhi:  move_res = hi_i;
            OpMflo:  move_res = lo_i;
            default: move_res = '0;
        endcase
    end

    // One restoring step: shift {rem,quo} left by one and keep the trial difference if non-negative.
    always_comb begin
        trial    = {rem_q, quo_q[31]} - {1'b0, divisor_q};
        step_rem = trial[32] ? {rem_q[30:0], quo_q[31]} : trial[31:0];
        step_quo = {quo_q[30:0], ~trial[32]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            res_lo_q  <= '0;
            res_hi_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (is_div) begin
                        if (reg2_i == 32'd0) begin
                            state_q <= StDivZero;
                        end else begin
                            state_q   <= StRun;
                            rem_q     <= '0;
                            quo_q     <= dividend_abs;
                            divisor_q <= divisor_abs;
                            cnt_q     <= '0;
                            neg_quo_q <= div_signed && (reg1_i[31] ^ reg2_i[31]);
                            neg_rem_q <= div_signed && reg1_i[31];
                        end
                    end
                end
                StRun: begin
                    rem_q <= step_rem;
                    quo_q <= step_quo;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == LastStep) begin
                        state_q  <= StDone;
                        res_lo_q <= neg_quo_q ? -step_quo : step_quo;
                        res_hi_q <= neg_rem_q ? -step_rem : step_rem;
                    end
                end
                StDivZero: begin
                    rem_q    <= '0;
                    quo_q    <= '0;
                    res_lo_q <= '0;
                    res_hi_q <= '0;
                    state_q  <= StDone;
                end
                StDone: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        wd_o     = NopRegAddr;
        wreg_o   = 1'b0;
        wdata_o  = '0;
        whilo_o  = 1'b0;
        hi_o     = '0;
        lo_o     = '0;
        stallreq = 1'b0;
        if (!rst) begin
            wd_o   = wd_i;
            wreg_o = is_div ? 1'b0 : wreg_i;
            case (alusel_i)
                SelLogic: wdata_o = logic_res;
                SelShift: wdata_o = shift_res;
                SelArith: wdata_o = arith_res;
                SelMove:  wdata_o = move_res;
                default:  wdata_o = '0;
            endcase
            if (state_q == StDone) begin
                whilo_o = 1'b1;
                lo_o    = res_lo_q;
                hi_o    = res_hi_q;
            end else if (aluop_i == OpMthi) begin
                whilo_o = 1'b1;
                hi_o    = reg1_i;
                lo_o    = lo_i;
            end else if (aluop_i == OpMtlo) begin
                whilo_o = 1'b1;
                hi_o    = hi_i;
                lo_o    = reg1_i;
            end
            stallreq = (state_q == StIdle && is_div) || (state_q == StRun)
                       || (state_q == StDivZero);
        end
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage pipeline. Consumes the decoded operation registered by the ID/EX pipeline register and produces the GPR write-back triple plus HI/LO write for the EX/MEM register.
- Single-cycle ALU for logic, shift, add/sub and compare operations.
- Iterative 32-cycle signed/unsigned divider. While busy it raises stallreq, so the stall controller freezes PC, IF/ID and ID/EX and holds this block's inputs stable.

Parameters:
- DIV_CYCLES, 32, number of restoring-division iterations; fixed by the 32-bit operand width; not overridable in practice.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset (`RstEnable = 1'b1).
- aluop_i  in  8  operation code, `AluOpBus, encodings per defines.v.
- alusel_i  in  3  result class, `AluSelBus: NOP, LOGIC, SHIFT, ARITH, MOVE.
- reg1_i  in  32  operand 1; dividend for DIV/DIVU.
- reg2_i  in  32  operand 2; divisor for DIV/DIVU; shift amount is reg1_i[4:0].
- wd_i  in  5  destination GPR address.
- wreg_i  in  1  GPR write enable.
- hi_i  in  32  current HI value, already forwarded by the surrounding logic.
- lo_i  in  32  current LO value, already forwarded by the surrounding logic.
- wd_o  out  5  destination GPR.
- wreg_o  out  1  GPR write enable.
- wdata_o  out  32  GPR write data.
- whilo_o  out  1  HI/LO write enable.
- hi_o  out  32  HI write data; remainder for divides.
- lo_o  out  32  LO write data; quotient for divides.
- stallreq  out  1  pipeline stall request.

Behaviour:
Reset:
- While rst=1, every output is 0 and wd_o = `NOPRegAddr.
- Divider FSM returns to IDLE; its remainder and quotient registers clear.
- Reset during a division aborts it; stallreq=0 in the same cycle.

Single-cycle ops (combinational from inputs; 0-cycle latency):
- OR, AND, XOR, NOR.
- SLL: reg2<<reg1[4:0]. SRL: logical right shift. SRA: arithmetic right shift (fills with reg2[31]).
- ADDU, SUBU: mod 2^32, no overflow detection.
- SLT: signed compare, result 1/0. SLTU: unsigned compare, result 1/0.
- MFHI -> hi_i. MFLO -> lo_i.
- wdata_o is selected by alusel_i; NOP or unknown class -> 0.
- wd_o=wd_i and wreg_o=wreg_i pass through.
- MTHI/MTLO: whilo_o=1 with hi_o=reg1 or lo_o=reg1, the other half held from hi_i/lo_i.

Divider FSM, states IDLE, RUN, DIVZERO, DONE:
- IDLE:
  - aluop is DIV/DIVU and reg2≠0 -> RUN. Latch |dividend| and |divisor| (raw values for DIVU), latch sign flags, clear counter; stallreq=1.
  - aluop is DIV/DIVU and reg2=0 -> DIVZERO; stallreq=1.
  - Otherwise stay in IDLE; stallreq=0.
- RUN:
  - One restoring step per cycle: shift {rem,quo} left, trial-subtract, set quotient bit.
  - Counter 0..31; after the 32nd step -> DONE. stallreq=1 throughout.
- DIVZERO: one cycle, result quotient=0, remainder=0 -> DONE.
- DONE:
  - stallreq=0; whilo_o=1; lo_o=quotient, hi_o=remainder.
  - Signed fixup: quotient negated if operand signs differ; remainder takes the dividend's sign.
  - Next state IDLE unconditionally.
- Timing: the DIV is presented at cycle 0 and DONE occurs at cycle 33, so stallreq is high for cycles 0..32 (33 cycles).
- At the DONE edge ID/EX loads the next instruction. A back-to-back DIV is then seen in IDLE and starts a fresh division.
- Divide results are meaningful only in DONE. During IDLE/RUN with a DIV op, whilo_o=0.
- Divide ops do not write the GPR: wreg_o is forced to 0 regardless of wreg_i.
- INT_MIN/-1 (signed): quotient 0x80000000, remainder 0 (wraps).

Test Plan:
- ORI-style OR, reg1=0x0000F0F0, reg2=0x00FF00FF, wd=5, wreg=1 -> same cycle wdata_o=0x00FFF0FF, wd_o=5, wreg_o=1, stallreq=0.
- SRA, reg1=4, reg2=0x80000000 -> wdata_o=0xF8000000. SLT reg1=0xFFFFFFFF, reg2=1 -> 1. SLTU with the same operands -> 0.
- DIVU, reg1=100, reg2=7, held stable -> stallreq high cycles 0..32. Cycle 33: whilo_o=1, lo_o=14, hi_o=2, stallreq=0, wreg_o=0.
- DIV, reg1=-7 (0xFFFFFFF9), reg2=2 -> lo_o=0xFFFFFFFD (-3), hi_o=0xFFFFFFFF (-1). Immediately followed by DIV 9/-4 -> second result lo=-2, hi=1 after another 33 stall cycles.
- DIV with reg2=0 -> stallreq high 2 cycles, then DONE: lo_o=0, hi_o=0, whilo_o=1.
- Assert rst at cycle 10 of a DIVU -> that cycle stallreq=0 and all outputs 0. After release with a non-divide op, FSM is IDLE and no whilo_o pulse appears.
